// File: rtl/fifo_param_if.sv
// fifo_param_if: write/read handshake, status and error-flag bundle for fifo_param.
// master is the FIFO user; slave is the FIFO itself.
interface fifo_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   logic                     wr_en;
   logic [WIDTH-1:0]         wr_data;
   logic                     rd_en;
   logic [WIDTH-1:0]         rd_data;
   logic                     rd_valid;
   logic                     full;
   logic                     empty;
   logic                     almost_full;
   logic                     almost_empty;
   logic [$clog2(DEPTH):0]   level;
   logic                     overflow;
   logic                     underflow;
   logic                     clr_err;
   modport master (
      output wr_en, wr_data, rd_en, clr_err,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty, level, overflow, underflow
   );
   modport slave (
      input  wr_en, wr_data, rd_en, clr_err,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty, level, overflow, underflow
   );
endinterface

// File: rtl/fifo_param.sv
// fifo_param: synchronous FIFO with registered-read or first-word-fall-through output,
// threshold flags and sticky overflow/underflow.
module fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2,
   parameter int FWFT      = 0
) (
   input  logic clk,
   input  logic rst,
   fifo_param_if.slave f
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L    = LW'(AFULL_TH);
   localparam logic [LW-1:0] AE_L    = LW'(AEMPTY_TH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [LW-1:0]    level;
   logic [WIDTH-1:0] rd_q;
   logic             rv_q, ovf, unf;
   logic             full, empty, wr_ok, rd_ok;

   assign full  = level == DEPTH_L;
   assign empty = level == '0;
   assign wr_ok = f.wr_en && !full;
   assign rd_ok = f.rd_en && !empty;

   always_ff @(posedge clk)
      if (wr_ok && !rst) mem[wptr] <= f.wr_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         rd_q  <= '0;
         rv_q  <= 1'b0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         wptr  <= wptr + AW'(wr_ok);
         rptr  <= rptr + AW'(rd_ok);
         level <= level + LW'(wr_ok) - LW'(rd_ok);
         rv_q  <= rd_ok;
         if (rd_ok) rd_q <= mem[rptr];
         // a fresh error event outranks a same-cycle clear
         ovf   <= (f.wr_en && full) || (ovf && !f.clr_err);
         unf   <= (f.rd_en && empty) || (unf && !f.clr_err);
      end
   end

   // FWFT shows the head word combinationally; zero while nothing is held
   assign f.rd_data      = (FWFT != 0) ? (empty ? '0 : mem[rptr]) : rd_q;
   assign f.rd_valid     = (FWFT != 0) ? !empty : rv_q;
   assign f.full         = full;
   assign f.empty        = empty;
   assign f.almost_full  = level >= AF_L;
   assign f.almost_empty = level <= AE_L;
   assign f.level        = level;
   assign f.overflow     = ovf;
   assign f.underflow    = unf;
endmodule
